// File: rtl/bip_system_if.sv
// Host-side bundle for bip_system: program load, run control, status and debug read.
// The core uses the slave modport; the host side (testbench or wrapper) uses master.
interface bip_system_if #(
  parameter int NB_BITS  = 16,
  parameter int NB_IADDR = 11,
  parameter int NB_DADDR = 10,
  parameter int NB_CNT   = 32
);
  logic                i_load_valid;
  logic [NB_IADDR-1:0] i_load_addr;
  logic [NB_BITS-1:0]  i_load_data;
  logic                o_load_ready;
  logic                i_start;
  logic                o_busy;
  logic                o_done;
  logic [NB_BITS-1:0]  o_acc;
  logic [NB_IADDR-1:0] o_pc;
  logic [NB_CNT-1:0]   o_cycles;
  logic [NB_CNT-1:0]   o_instr_count;
  logic [NB_DADDR-1:0] i_dbg_addr;
  logic [NB_BITS-1:0]  o_dbg_data;

  modport master (
    output i_load_valid, i_load_addr, i_load_data, i_start, i_dbg_addr,
    input  o_load_ready, o_busy, o_done, o_acc, o_pc, o_cycles, o_instr_count, o_dbg_data
  );

  modport slave (
    input  i_load_valid, i_load_addr, i_load_data, i_start, i_dbg_addr,
    output o_load_ready, o_busy, o_done, o_acc, o_pc, o_cycles, o_instr_count, o_dbg_data
  );
endinterface

// File: rtl/bip_system.sv
// BIP single-accumulator processor: program memory loaded by the host, a 3-cycle
// FETCH/DECODE/EXEC core, dual-port data memory with a debug read port, and run counters.
module bip_system #(
  parameter int NB_BITS        = 16,
  parameter int NB_OPCODE      = 5,
  parameter int INS_MEM_DEPTH  = 2048,
  parameter int DATA_MEM_DEPTH = 1024,
  parameter int NB_CNT         = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  bip_system_if.slave       host
);
  localparam int NB_IADDR = $clog2(INS_MEM_DEPTH);
  localparam int NB_DADDR = $clog2(DATA_MEM_DEPTH);
  localparam int NB_OPR   = NB_BITS - NB_OPCODE;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  localparam logic [NB_OPCODE-1:0] OP_HLT  = NB_OPCODE'(0);
  localparam logic [NB_OPCODE-1:0] OP_STO  = NB_OPCODE'(1);
  localparam logic [NB_OPCODE-1:0] OP_LD   = NB_OPCODE'(2);
  localparam logic [NB_OPCODE-1:0] OP_LDI  = NB_OPCODE'(3);
  localparam logic [NB_OPCODE-1:0] OP_ADD  = NB_OPCODE'(4);
  localparam logic [NB_OPCODE-1:0] OP_ADDI = NB_OPCODE'(5);
  localparam logic [NB_OPCODE-1:0] OP_SUB  = NB_OPCODE'(6);
  localparam logic [NB_OPCODE-1:0] OP_SUBI = NB_OPCODE'(7);

  logic [2:0]          r_state;
  logic [NB_BITS-1:0]  r_imem [INS_MEM_DEPTH];
  logic [NB_BITS-1:0]  r_dmem [DATA_MEM_DEPTH];
  logic [NB_BITS-1:0]  r_ir;
  logic [NB_BITS-1:0]  r_dmem_q;
  logic [NB_BITS-1:0]  r_acc;
  logic [NB_BITS-1:0]  r_dbg_data;
  logic [NB_IADDR-1:0] r_pc;
  logic [NB_CNT-1:0]   r_cycles;
  logic [NB_CNT-1:0]   r_instr_count;

  logic                w_host_side;
  logic                w_busy;
  logic                w_load_we;
  logic                w_sto_we;
  logic [NB_OPCODE-1:0] w_opcode;
  logic [NB_OPR-1:0]   w_operand;
  logic [NB_BITS-1:0]  w_imm;
  logic [NB_DADDR-1:0] w_daddr;
  logic [NB_IADDR-1:0] w_pc_next;

  function automatic logic [NB_CNT-1:0] satInc(input logic [NB_CNT-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_host_side = (r_state == ST_IDLE) || (r_state == ST_HALT);
  assign w_busy      = (r_state == ST_FETCH) || (r_state == ST_DECODE) || (r_state == ST_EXEC);
  assign w_load_we   = w_host_side && host.i_load_valid;
  assign w_opcode    = r_ir[NB_BITS-1 -: NB_OPCODE];
  assign w_operand   = r_ir[NB_OPR-1:0];
  assign w_imm       = {{NB_OPCODE{w_operand[NB_OPR-1]}}, w_operand};
  assign w_daddr     = w_operand[NB_DADDR-1:0];
  assign w_sto_we    = (r_state == ST_EXEC) && (w_opcode == OP_STO);
  assign w_pc_next   = (r_pc == NB_IADDR'(INS_MEM_DEPTH - 1)) ? '0 : r_pc + 1'b1;

  // Memories carry no reset so their contents survive a reset pulse.
  always_ff @(posedge i_clk) begin
    if (w_load_we) r_imem[host.i_load_addr] <= host.i_load_data;
    if (r_state == ST_FETCH) r_ir <= r_imem[r_pc];
  end

  always_ff @(posedge i_clk) begin
    if (w_sto_we) r_dmem[w_daddr] <= r_acc;
    if (r_state == ST_DECODE) r_dmem_q <= r_dmem[w_daddr];
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_dbg_data <= '0;
    else        r_dbg_data <= r_dmem[host.i_dbg_addr];
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state       <= ST_IDLE;
      r_acc         <= '0;
      r_pc          <= '0;
      r_cycles      <= '0;
      r_instr_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HALT: begin
          if (host.i_start) begin
            r_state       <= ST_FETCH;
            r_acc         <= '0;
            r_pc          <= '0;
            r_cycles      <= '0;
            r_instr_count <= '0;
          end
        end
        ST_FETCH: begin
          r_state  <= ST_DECODE;
          r_cycles <= satInc(r_cycles);
        end
        ST_DECODE: begin
          r_state  <= (w_opcode == OP_HLT) ? ST_HALT : ST_EXEC;
          r_cycles <= satInc(r_cycles);
        end
        ST_EXEC: begin
          case (w_opcode)
            OP_LD:   r_acc <= r_dmem_q;
            OP_LDI:  r_acc <= w_imm;
            OP_ADD:  r_acc <= r_acc + r_dmem_q;
            OP_ADDI: r_acc <= r_acc + w_imm;
            OP_SUB:  r_acc <= r_acc - r_dmem_q;
            OP_SUBI: r_acc <= r_acc - w_imm;
            default: r_acc <= r_acc;
          endcase
          r_pc          <= w_pc_next;
          r_instr_count <= satInc(r_instr_count);
          r_cycles      <= satInc(r_cycles);
          r_state       <= ST_FETCH;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign host.o_load_ready  = w_host_side;
  assign host.o_busy        = w_busy;
  assign host.o_done        = (r_state == ST_HALT);
  assign host.o_acc         = r_acc;
  assign host.o_pc          = r_pc;
  assign host.o_cycles      = r_cycles;
  assign host.o_instr_count = r_instr_count;
  assign host.o_dbg_data    = r_dbg_data;
endmodule

// File: tb/tb_bip_system.sv
// Self-checking bench for bip_system: directed programs plus randomized programs
// compared against an instruction-level interpreter of the BIP instruction set.
module tb_bip_system;
  localparam int NB_BITS    = 16;
  localparam int INS_DEPTH  = 8;
  localparam int DATA_DEPTH = 1024;
  localparam int NB_IADDR   = 3;
  localparam int NB_DADDR   = 10;
  localparam int NB_CNT     = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  logic [15:0] modelImem [INS_DEPTH];
  logic [15:0] modelDmem [DATA_DEPTH];
  logic [15:0] progQ [$];

  bip_system_if #(.NB_BITS(NB_BITS), .NB_IADDR(NB_IADDR), .NB_DADDR(NB_DADDR), .NB_CNT(NB_CNT)) host ();

  bip_system #(
    .NB_BITS(NB_BITS), .NB_OPCODE(5), .INS_MEM_DEPTH(INS_DEPTH),
    .DATA_MEM_DEPTH(DATA_DEPTH), .NB_CNT(NB_CNT)
  ) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .host(host)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] mkInstr(input int op, input int operand);
    logic [15:0] w;
    w = 16'((op % 32) * 2048 + (operand % 2048));
    return w;
  endfunction

  task automatic loadWord(input int addr, input logic [15:0] data);
    @(posedge clk); #1;
    host.i_load_valid = 1'b1;
    host.i_load_addr  = NB_IADDR'(addr);
    host.i_load_data  = data;
    @(posedge clk); #1;
    host.i_load_valid = 1'b0;
    modelImem[addr] = data;
  endtask

  task automatic loadProgram();
    foreach (progQ[i]) loadWord(i, progQ[i]);
  endtask

  task automatic startRun();
    @(posedge clk); #1;
    host.i_start = 1'b1;
    @(posedge clk); #1;
    host.i_start = 1'b0;
  endtask

  task automatic waitDone(input int maxCycles);
    int n;
    n = 0;
    while (!host.o_done && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    if (!host.o_done) checkOutput("doneTimeout", 64'd0, 64'd1);
  endtask

  task automatic readDbg(input int addr, output logic [15:0] data);
    @(posedge clk); #1;
    host.i_dbg_addr = NB_DADDR'(addr);
    @(posedge clk);
    @(negedge clk);
    data = host.o_dbg_data;
  endtask

  // Instruction-level interpreter: walks the program image, returns architectural results.
  task automatic runModel(output logic [15:0] acc, output int pc, output int instr, output int cycles);
    int p, n, a, op, opnd, imm, addr;
    logic [15:0] w;
    p = 0; n = 0; a = 0;
    for (int step = 0; step < 200; step++) begin
      w = modelImem[p];
      op = int'(w) / 2048;
      opnd = int'(w) % 2048;
      if (op == 0) break;
      imm = (opnd >= 1024) ? opnd - 2048 : opnd;
      addr = opnd % DATA_DEPTH;
      case (op)
        1: modelDmem[addr] = a[15:0];
        2: a = int'(modelDmem[addr]);
        3: a = imm;
        4: a = a + int'(modelDmem[addr]);
        5: a = a + imm;
        6: a = a - int'(modelDmem[addr]);
        7: a = a - imm;
        default: ;
      endcase
      a = a & 32'hFFFF;
      p = (p + 1) % INS_DEPTH;
      n++;
    end
    acc = a[15:0];
    pc = p;
    instr = n;
    cycles = 3 * n + 2;
  endtask

  task automatic checkRun(input string tag, input int expAcc, input int expPc, input int expInstr, input int expCycles);
    checkOutput({tag, ".acc"}, 64'(host.o_acc), 64'(expAcc));
    checkOutput({tag, ".pc"}, 64'(host.o_pc), 64'(expPc));
    checkOutput({tag, ".instr"}, 64'(host.o_instr_count), 64'(expInstr));
    checkOutput({tag, ".cycles"}, 64'(host.o_cycles), 64'(expCycles));
  endtask

  task automatic applyStimulus(input int idx);
    int len, op, opnd, mPc, mInstr, mCycles, dAddr;
    logic [15:0] mAcc, dData;
    len = $urandom_range(1, INS_DEPTH - 1);
    progQ = {};
    for (int i = 0; i < len; i++) begin
      op = $urandom_range(1, 9);
      if (op >= 8) op = $urandom_range(8, 31);
      if (op == 1 || op == 2 || op == 4 || op == 6)
        opnd = $urandom_range(0, 1) * 1024 + $urandom_range(0, 3);
      else
        opnd = $urandom_range(0, 2047);
      progQ.push_back(mkInstr(op, opnd));
    end
    progQ.push_back(16'h0000);
    loadProgram();
    runModel(mAcc, mPc, mInstr, mCycles);
    startRun();
    waitDone(60);
    checkRun($sformatf("rand%0d", idx), int'(mAcc), mPc, mInstr, mCycles);
    dAddr = $urandom_range(0, 3);
    readDbg(dAddr, dData);
    checkOutput($sformatf("rand%0d.dbg", idx), 64'(dData), 64'(modelDmem[dAddr]));
  endtask

  initial begin
    logic [15:0] dData, mAcc;
    int mPc, mInstr, mCycles;
    host.i_load_valid = 1'b0;
    host.i_load_addr  = '0;
    host.i_load_data  = '0;
    host.i_start      = 1'b0;
    host.i_dbg_addr   = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst.ready", 64'(host.o_load_ready), 64'd1);
    checkOutput("rst.busy", 64'(host.o_busy), 64'd0);
    checkOutput("rst.done", 64'(host.o_done), 64'd0);
    checkOutput("rst.acc", 64'(host.o_acc), 64'd0);
    checkOutput("rst.pc", 64'(host.o_pc), 64'd0);
    checkOutput("rst.cycles", 64'(host.o_cycles), 64'd0);
    checkOutput("rst.instr", 64'(host.o_instr_count), 64'd0);
    checkOutput("rst.dbg", 64'(host.o_dbg_data), 64'd0);
    rst_n = 1'b1;

    // Lone HLT: busy one cycle after start, done after FETCH+DECODE.
    loadWord(0, 16'h0000);
    startRun();
    @(negedge clk);
    checkOutput("hlt.busy", 64'(host.o_busy), 64'd1);
    checkOutput("hlt.readyBusy", 64'(host.o_load_ready), 64'd0);
    @(negedge clk);
    checkOutput("hlt.doneEarly", 64'(host.o_done), 64'd0);
    @(negedge clk);
    checkOutput("hlt.done", 64'(host.o_done), 64'd1);
    checkRun("hlt", 0, 0, 0, 2);

    progQ = '{16'h1805, 16'h2803, 16'h080A, 16'h100A, 16'h3801, 16'h0000};
    loadProgram();
    startRun();
    waitDone(60);
    checkRun("example", 7, 5, 5, 17);
    readDbg(10, dData);
    checkOutput("example.dbg10", 64'(dData), 64'd8);

    progQ = '{16'h1FFF, 16'h3FFF, 16'h0000};
    loadProgram();
    startRun();
    waitDone(30);
    checkRun("sext.subi", 0, 2, 2, 8);
    progQ = '{16'h1FFF, 16'h0000};
    loadProgram();
    startRun();
    waitDone(30);
    checkRun("sext.ldi", 16'hFFFF, 1, 1, 5);

    // Load and start pulses in the middle of a run must be ignored.
    progQ = '{16'h1805, 16'h2803, 16'h080A, 16'h100A, 16'h3801, 16'h0000};
    loadProgram();
    startRun();
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    host.i_load_valid = 1'b1;
    host.i_load_addr  = '0;
    host.i_load_data  = 16'h0000;
    host.i_start      = 1'b1;
    @(negedge clk);
    checkOutput("disturb.ready", 64'(host.o_load_ready), 64'd0);
    @(posedge clk); #1;
    host.i_load_valid = 1'b0;
    host.i_start      = 1'b0;
    waitDone(60);
    checkRun("disturb", 7, 5, 5, 17);
    startRun();
    waitDone(60);
    checkRun("restart", 7, 5, 5, 17);

    // Load and start in the same cycle: the first fetch sees the new word.
    @(posedge clk); #1;
    host.i_load_valid = 1'b1;
    host.i_load_addr  = '0;
    host.i_load_data  = 16'h0000;
    host.i_start      = 1'b1;
    @(posedge clk); #1;
    host.i_load_valid = 1'b0;
    host.i_start      = 1'b0;
    modelImem[0] = 16'h0000;
    waitDone(30);
    checkRun("loadStart", 0, 0, 0, 2);

    progQ = '{mkInstr(3, $urandom_range(0, 2047)), mkInstr(1, 0), mkInstr(3, $urandom_range(0, 2047)),
              mkInstr(1, 1), mkInstr(3, $urandom_range(0, 2047)), mkInstr(1, 2), mkInstr(1, 3), 16'h0000};
    loadProgram();
    runModel(mAcc, mPc, mInstr, mCycles);
    startRun();
    waitDone(60);
    checkRun("init", int'(mAcc), mPc, mInstr, mCycles);
    for (int t = 0; t < 10; t++) applyStimulus(t);

    // PC wrap: eight ADDI 1 with no HLT; pc returns to 0 after the eighth.
    progQ = '{16'h2801, 16'h2801, 16'h2801, 16'h2801, 16'h2801, 16'h2801, 16'h2801, 16'h2801};
    loadProgram();
    startRun();
    repeat (25) @(negedge clk);
    checkOutput("wrap.busy", 64'(host.o_busy), 64'd1);
    checkRun("wrap", 8, 0, 8, 24);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    checkOutput("midRst.busy", 64'(host.o_busy), 64'd0);
    checkOutput("midRst.ready", 64'(host.o_load_ready), 64'd1);
    checkOutput("midRst.done", 64'(host.o_done), 64'd0);
    checkRun("midRst", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    loadWord(7, 16'h0000);
    startRun();
    waitDone(60);
    checkRun("afterRst", 7, 7, 7, 23);
    readDbg(10, dData);
    checkOutput("afterRst.dbg10", 64'(dData), 64'd8);
    loadWord(0, 16'h0000);
    startRun();
    waitDone(30);
    checkRun("hltAt0", 0, 0, 0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
